// File: rtl/tm1638_seg7_hex_writer.sv
// tm1638_seg7_hex_writer: writes a 32-bit value as hex 7-segment bytes plus an LED
// mask into the LED&KEY display memory window, kicks a refresh, then reports done.
// Optional build macro TM1638_SEG7_LZ_BLANK_EN blanks leading zero digits.
module tm1638_seg7_hex_writer #(
    parameter int          SEG7_COUNT     = 8,
    parameter int          LED_COUNT      = 8,
    parameter logic [15:0] SEG7_BASE_ADDR = 16'h0100,
    parameter logic [15:0] LED_BASE_ADDR  = 16'h0200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_value,
    input  logic [7:0]  i_dp_mask,
    input  logic [7:0]  i_leds,
    output logic        o_wr_en,
    output logic [15:0] o_wr_addr,
    output logic [7:0]  o_wr_data,
    input  logic        i_disp_idle,
    output logic        o_disp_en,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [2:0] {S_IDLE, S_SEG, S_LED, S_KICK, S_GUARD, S_WAIT} state_t;

    localparam logic [2:0] SEG_LAST = 3'(SEG7_COUNT - 1);
    localparam logic [2:0] LED_LAST = 3'(LED_COUNT - 1);

    state_t      state, state_nx;
    logic [2:0]  idx, idx_nx;
    logic [31:0] value_q, value_nx;
    logic [7:0]  dp_q, dp_nx;
    logic [7:0]  leds_q, leds_nx;
    logic        wr_en_nx, disp_en_nx, busy_nx, done_nx;
    logic [15:0] wr_addr_nx;
    logic [7:0]  wr_data_nx;

    function automatic logic [7:0] font(input logic [3:0] n);
        logic [7:0] f;
        case (n)
            4'h0: f = 8'h3F;  4'h1: f = 8'h06;  4'h2: f = 8'h5B;  4'h3: f = 8'h4F;
            4'h4: f = 8'h66;  4'h5: f = 8'h6D;  4'h6: f = 8'h7D;  4'h7: f = 8'h07;
            4'h8: f = 8'h7F;  4'h9: f = 8'h6F;  4'hA: f = 8'h77;  4'hB: f = 8'h7C;
            4'hC: f = 8'h39;  4'hD: f = 8'h5E;  4'hE: f = 8'h79;  default: f = 8'h71;
        endcase
        return f;
    endfunction

    // Segment byte {dp,g..a} for digit k; digit 0 is the most significant shown nibble.
    function automatic logic [7:0] seg_byte(input logic [31:0] v, input logic [7:0] dp,
                                            input logic [2:0] k);
        logic [7:0] pat;
        pat = font(4'(v >> (4 * (SEG7_COUNT - 1 - int'(k)))));
`ifdef TM1638_SEG7_LZ_BLANK_EN
        begin
            logic lead;
            // The rightmost digit always shows, so a zero value still reads "0".
            lead = (int'(k) != SEG7_COUNT - 1);
            for (int j = 0; j < SEG7_COUNT; j++) begin
                if (j <= int'(k) && 4'(v >> (4 * (SEG7_COUNT - 1 - j))) != 4'h0)
                    lead = 1'b0;
            end
            if (lead)
                pat = 8'h00;
        end
`endif
        return pat | {dp[k], 7'b0};
    endfunction

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        value_nx   = value_q;
        dp_nx      = dp_q;
        leds_nx    = leds_q;
        wr_en_nx   = 1'b0;
        wr_addr_nx = o_wr_addr;
        wr_data_nx = o_wr_data;
        disp_en_nx = 1'b0;
        busy_nx    = o_busy;
        done_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                // A start landing on the o_done cycle is dropped, not queued.
                if (i_start && !o_done) begin
                    value_nx   = i_value;
                    dp_nx      = i_dp_mask;
                    leds_nx    = i_leds;
                    idx_nx     = 3'd0;
                    state_nx   = S_SEG;
                    busy_nx    = 1'b1;
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = SEG7_BASE_ADDR;
                    wr_data_nx = seg_byte(i_value, i_dp_mask, 3'd0);
                end
            end
            S_SEG: begin
                wr_en_nx = 1'b1;
                if (idx == SEG_LAST) begin
                    idx_nx     = 3'd0;
                    state_nx   = S_LED;
                    wr_addr_nx = LED_BASE_ADDR;
                    wr_data_nx = {7'b0, leds_q[0]};
                end else begin
                    idx_nx     = idx + 3'd1;
                    wr_addr_nx = SEG7_BASE_ADDR + {13'b0, idx_nx};
                    wr_data_nx = seg_byte(value_q, dp_q, idx_nx);
                end
            end
            S_LED: begin
                if (idx == LED_LAST) begin
                    // Kick right behind the last write when the driver is already idle.
                    if (i_disp_idle) begin
                        disp_en_nx = 1'b1;
                        state_nx   = S_GUARD;
                    end else begin
                        state_nx   = S_KICK;
                    end
                end else begin
                    idx_nx     = idx + 3'd1;
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = LED_BASE_ADDR + {13'b0, idx_nx};
                    wr_data_nx = {7'b0, leds_q[idx_nx]};
                end
            end
            S_KICK: begin
                if (i_disp_idle) begin
                    disp_en_nx = 1'b1;
                    state_nx   = S_GUARD;
                end
            end
            // The driver still reports idle while the kick is on the wire.
            S_GUARD: state_nx = S_WAIT;
            S_WAIT: begin
                if (i_disp_idle) begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            value_q   <= 32'd0;
            dp_q      <= 8'd0;
            leds_q    <= 8'd0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= 16'd0;
            o_wr_data <= 8'd0;
            o_disp_en <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            value_q   <= value_nx;
            dp_q      <= dp_nx;
            leds_q    <= leds_nx;
            o_wr_en   <= wr_en_nx;
            o_wr_addr <= wr_addr_nx;
            o_wr_data <= wr_data_nx;
            o_disp_en <= disp_en_nx;
            o_busy    <= busy_nx;
            o_done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_tm1638_seg7_hex_writer.sv
// Bench for tm1638_seg7_hex_writer: scoreboard of expected display-memory writes
// derived from the value/dp/led rules, plus directed timing checks per update.
module tb_tm1638_seg7_hex_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = 32'd0;
    logic [7:0]  dp = 8'd0;
    logic [7:0]  leds = 8'd0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        disp_idle;
    logic        disp_en;
    logic        busy;
    logic        done;

    logic        force_low = 1'b0;
    int          rcnt = 0;
    int          tests = 0;
    int          fails = 0;
    logic [23:0] exp_q[$];
    logic [15:0] last_addr = 16'd0;
    logic [7:0]  last_data = 8'd0;

    localparam logic [7:0] FONT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                         8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    localparam logic [7:0] T2_SEG [8] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    localparam logic [7:0] T2_LED [8] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};

    tm1638_seg7_hex_writer dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_value    (value),
        .i_dp_mask  (dp),
        .i_leds     (leds),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .i_disp_idle(disp_idle),
        .o_disp_en  (disp_en),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    // Display driver stand-in: idle falls the cycle after the kick, busy for 4 cycles.
    always @(posedge clk) begin
        if (disp_en) rcnt <= 4;
        else if (rcnt != 0) rcnt <= rcnt - 1;
    end
    assign disp_idle = (rcnt == 0) && !force_low;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected segment byte: the shown nibble is the value shifted down past the
    // less-significant digits; a digit is leading when nothing non-zero remains above it.
    function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic [7:0] m, input int i);
        logic [31:0] upper;
        logic [7:0]  b;
        upper = v >> (4 * (7 - i));
        b = FONT[upper[3:0]];
`ifdef TM1638_SEG7_LZ_BLANK_EN
        if (i != 7 && upper == 32'd0) b = 8'h00;
`endif
        if (m[i]) b[7] = 1'b1;
        return b;
    endfunction

    task automatic push_model(input logic [31:0] v, input logic [7:0] m, input logic [7:0] l);
        for (int i = 0; i < 8; i++) exp_q.push_back({16'(16'h0100 + i), exp_seg(v, m, i)});
        for (int i = 0; i < 8; i++) exp_q.push_back({16'(16'h0200 + i), 7'b0, l[i]});
    endtask

    // Scoreboard: every write must be the next expected byte; otherwise the bus must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_addr = 16'd0;
            last_data = 8'd0;
        end else if (wr_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", wr_addr, wr_data);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[23:8]));
                check("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
            last_addr = wr_addr;
            last_data = wr_data;
        end else begin
            check("addr_hold", 32'(wr_addr), 32'(last_addr));
            check("data_hold", 32'(wr_data), 32'(last_data));
        end
    end

    task automatic kick(input logic [31:0] v, input logic [7:0] m, input logic [7:0] l);
        @(negedge clk);
        value = v; dp = m; leds = l; start = 1'b1;
        @(posedge clk);
    endtask

    // Observe one update; cycle 1 is the cycle right after the start-sampling edge.
    task automatic expect_update(input string tag, input int stall_until, input bit poke,
                                 input bit hold, input int want_first, input int want_disp,
                                 input int want_q);
        int first_wr, disp_cyc, disp_cnt, n_wr, done_cyc;
        first_wr = -1; disp_cyc = -1; disp_cnt = 0; n_wr = 0; done_cyc = -1;
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (wr_en) begin
                n_wr++;
                if (first_wr < 0) begin
                    first_wr = c;
                    check({tag, "_busy_during"}, 32'(busy), 32'd1);
                end
            end
            if (disp_en) begin disp_cnt++; disp_cyc = c; end
            if (done) begin
                done_cyc = c;
                check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            end
            if (!hold && c == 1) start = 1'b0;
            if (poke && (c == 5 || c == 20)) begin
                start = 1'b1; value = $urandom; dp = 8'($urandom); leds = 8'($urandom);
            end
            if (poke && (c == 6 || c == 21)) start = 1'b0;
            if (c == stall_until) force_low = 1'b0;
        end
        if (done_cyc < 0) begin
            tests++; fails++;
            $display("FAIL %s_done_timeout: got no o_done in 200 cycles, required one", tag);
        end
        check({tag, "_first_wr"}, 32'(first_wr), 32'(want_first));
        check({tag, "_n_wr"}, 32'(n_wr), 32'd16);
        check({tag, "_disp_cyc"}, 32'(disp_cyc), 32'(want_disp));
        check({tag, "_disp_cnt"}, 32'(disp_cnt), 32'd1);
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(want_disp + 6));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'(want_q));
    endtask

    initial begin
        int cnt;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_disp_en", 32'(disp_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin @(negedge clk); if (wr_en) cnt++; end
        check("idle_no_writes", 32'(cnt), 32'd0);

        // Model pinned against hand-computed bytes
        check("pin_1234_d0", 32'(exp_seg(32'h12345678, 8'h00, 0)), 32'h06);
        check("pin_1234_d7", 32'(exp_seg(32'h12345678, 8'h00, 7)), 32'h7F);
        check("pin_abcd_d7", 32'(exp_seg(32'h0000ABCD, 8'h80, 7)), 32'hDE);
`ifdef TM1638_SEG7_LZ_BLANK_EN
        check("pin_abcd_d0", 32'(exp_seg(32'h0000ABCD, 8'h80, 0)), 32'h00);
        check("pin_zero_d7", 32'(exp_seg(32'h0, 8'h00, 7)), 32'h3F);
`else
        check("pin_abcd_d0", 32'(exp_seg(32'h0000ABCD, 8'h80, 0)), 32'h3F);
`endif

        // 12345678 with literal expected bytes
        for (int i = 0; i < 8; i++) exp_q.push_back({16'(16'h0100 + i), T2_SEG[i]});
        for (int i = 0; i < 8; i++) exp_q.push_back({16'(16'h0200 + i), T2_LED[i]});
        kick(32'h12345678, 8'h00, 8'hA5);
        expect_update("u1234", 0, 1'b0, 1'b0, 1, 17, 0);

        // Leading zeros, decimal point, all-zero value
        push_model(32'h0000ABCD, 8'h80, 8'h00);
        kick(32'h0000ABCD, 8'h80, 8'h00);
        expect_update("uabcd", 0, 1'b0, 1'b0, 1, 17, 0);
        push_model(32'h0, 8'h00, 8'hFF);
        kick(32'h0, 8'h00, 8'hFF);
        expect_update("uzero", 0, 1'b0, 1'b0, 1, 17, 0);

        // Driver busy after last write, plus ignored start pulses mid-update
        force_low = 1'b1;
        push_model(32'hDEADBEEF, 8'h5A, 8'h3C);
        kick(32'hDEADBEEF, 8'h5A, 8'h3C);
        expect_update("ustall", 26, 1'b1, 1'b0, 1, 27, 0);

        // Asynchronous reset during write 5
        push_model(32'h89ABCDEF, 8'h01, 8'hF0);
        kick(32'h89ABCDEF, 8'h01, 8'hF0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr_en", 32'(wr_en), 32'd0);
        check("arst_addr", 32'(wr_addr), 32'd0);
        check("arst_data", 32'(wr_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        cnt = 0;
        repeat (3) begin @(negedge clk); if (disp_en) cnt++; end
        rst_n = 1'b1;
        repeat (12) begin @(negedge clk); if (disp_en || wr_en) cnt++; end
        check("arst_quiet", 32'(cnt), 32'd0);
        push_model(32'h89ABCDEF, 8'h01, 8'hF0);
        kick(32'h89ABCDEF, 8'h01, 8'hF0);
        expect_update("urestart", 0, 1'b0, 1'b0, 1, 17, 0);

        // Start held high: second update waits past the o_done cycle
        push_model(32'hCAFE0123, 8'hFF, 8'h81);
        push_model(32'hCAFE0123, 8'hFF, 8'h81);
        kick(32'hCAFE0123, 8'hFF, 8'h81);
        expect_update("ub2b_a", 0, 1'b0, 1'b1, 1, 17, 16);
        expect_update("ub2b_b", 0, 1'b0, 1'b1, 2, 18, 0);
        start = 1'b0;
        cnt = 0;
        repeat (20) begin @(negedge clk); if (wr_en || disp_en) cnt++; end
        check("b2b_no_third", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
